// File: rtl/image_buffer_ctrl_if.sv
// Bus bundle for image_buffer_ctrl: input pixel stream, output pixel stream, BRAM port and status.
// The master modport is the controller's view; slave is the surrounding system.
interface image_buffer_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              read_request;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;
    logic              image_written;
    logic              frame_done;

    modport master (
        input  s_valid, s_data, read_request, m_ready, bram_dout,
        output s_ready, m_valid, m_data, m_last, bram_we, bram_addr, bram_din,
               image_written, frame_done
    );

    modport slave (
        output s_valid, s_data, read_request, m_ready, bram_dout,
        input  s_ready, m_valid, m_data, m_last, bram_we, bram_addr, bram_din,
               image_written, frame_done
    );
endinterface

// File: rtl/image_buffer_ctrl.sv
// Fill/drain sequencer for the single-port image BRAM: writes one image from the input stream,
// then streams it out in raster order through a 2-entry skid buffer.
module image_buffer_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 16,
    parameter int NUM_PIXELS = 784
) (
    input logic                 clk,
    input logic                 rst,
    image_buffer_ctrl_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic              we_q;
    logic [DATA_W-1:0] din_q;
    logic              rd_done;
    logic              dout_v;
    logic              dout_last;
    logic              out_v;
    logic              out_last;
    logic [DATA_W-1:0] out_data;
    logic              spare_v;
    logic              spare_last;
    logic [DATA_W-1:0] spare_data;
    logic              iw_q;
    logic              fd_q;

    logic       accept;
    logic       pop;
    logic       issue;
    logic [1:0] occ;

    assign accept = (state == S_FILL) && bus.s_valid;
    assign pop    = out_v && bus.m_ready;
    // Occupancy counts the beat leaving this cycle as gone, so a new read can be issued
    // every cycle under continuous m_ready without risking overflow on a later stall.
    assign occ    = {1'b0, out_v} + {1'b0, spare_v} + {1'b0, dout_v} - {1'b0, pop};
    assign issue  = (state == S_DRAIN) && !rd_done && (occ < 2'd2);

    assign bus.s_ready       = (state == S_FILL);
    assign bus.bram_we       = we_q;
    assign bus.bram_din      = din_q;
    assign bus.bram_addr     = (state == S_DRAIN) ? rd_ptr : wr_addr;
    assign bus.m_valid       = out_v;
    assign bus.m_data        = out_data;
    assign bus.m_last        = out_last;
    assign bus.image_written = iw_q;
    assign bus.frame_done    = fd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_addr    <= '0;
            we_q       <= 1'b0;
            din_q      <= '0;
            rd_done    <= 1'b0;
            dout_v     <= 1'b0;
            dout_last  <= 1'b0;
            out_v      <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            spare_v    <= 1'b0;
            spare_last <= 1'b0;
            spare_data <= '0;
            iw_q       <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            fd_q      <= 1'b0;
            dout_v    <= issue;
            dout_last <= (rd_ptr == LAST_ADDR);

            case (state)
                S_IDLE: state <= S_FILL;
                S_FILL: begin
                    if (accept) begin
                        we_q    <= 1'b1;
                        wr_addr <= wr_ptr;
                        din_q   <= bus.s_data;
                        if (wr_ptr == LAST_ADDR) state <= S_FULL;
                        else                     wr_ptr <= wr_ptr + 1'b1;
                    end
                end
                S_FULL: begin
                    iw_q <= 1'b1;
                    if (bus.read_request) state <= S_DRAIN;
                end
                default: begin
                    if (issue) begin
                        if (rd_ptr == LAST_ADDR) rd_done <= 1'b1;
                        else                     rd_ptr  <= rd_ptr + 1'b1;
                    end
                    if (pop && out_last) begin
                        state   <= S_IDLE;
                        fd_q    <= 1'b1;
                        iw_q    <= 1'b0;
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        wr_addr <= '0;
                        rd_done <= 1'b0;
                    end
                end
            endcase

            // Skid buffer: output register backed by one spare entry.
            if (!out_v || pop) begin
                if (spare_v) begin
                    out_v      <= 1'b1;
                    out_data   <= spare_data;
                    out_last   <= spare_last;
                    spare_v    <= dout_v;
                    spare_data <= bus.bram_dout;
                    spare_last <= dout_last;
                end else if (dout_v) begin
                    out_v    <= 1'b1;
                    out_data <= bus.bram_dout;
                    out_last <= dout_last;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (dout_v) begin
                spare_v    <= 1'b1;
                spare_data <= bus.bram_dout;
                spare_last <= dout_last;
            end
        end
    end
endmodule

// File: tb/tb_image_buffer_ctrl.sv
// Randomized scoreboard bench for image_buffer_ctrl: an image-level reference model queues
// expected BRAM writes and output beats; a negedge monitor compares whatever the DUT presents.
module tb_image_buffer_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int N      = 784;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    image_buffer_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    image_buffer_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PIXELS(N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Synchronous single-port BRAM behaviour
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
        bus.bram_dout <= mem[bus.bram_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Image-level reference model
    typedef enum int {P_IDLE, P_FILL, P_FULL, P_DRAIN} ph_t;
    typedef struct packed {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} wr_t;
    typedef struct packed {logic [DATA_W-1:0] d; logic l;} px_t;

    ph_t               ph = P_IDLE;
    int                nacc = 0;
    logic [DATA_W-1:0] img [N];
    wr_t               wq[$];
    px_t               oq[$];
    logic              iw_exp = 1'b0;
    logic              fd_exp = 1'b0;
    int                cyc = 0;
    int                req_cyc = 0;
    int                req_n = 0;
    int                last_hs_cyc = -1;
    int                npop = 0;

    always @(posedge clk) begin
        wr_t w;
        px_t p;
        fd_exp = 1'b0;
        if (rst) begin
            ph = P_IDLE;
            nacc = 0;
            wq.delete();
            oq.delete();
            iw_exp = 1'b0;
        end else begin
            case (ph)
                P_IDLE: ph = P_FILL;
                P_FILL: if (bus.s_valid) begin
                    img[nacc] = bus.s_data;
                    w.a = ADDR_W'(nacc);
                    w.d = bus.s_data;
                    wq.push_back(w);
                    nacc++;
                    if (nacc == N) ph = P_FULL;
                end
                P_FULL: begin
                    iw_exp = 1'b1;
                    if (bus.read_request) begin
                        ph = P_DRAIN;
                        req_cyc = cyc;
                        req_n++;
                        for (int i = 0; i < N; i++) begin
                            p.d = img[i];
                            p.l = (i == N - 1);
                            oq.push_back(p);
                        end
                    end
                end
                P_DRAIN: if (last_hs_cyc == cyc) begin
                    ph = P_IDLE;
                    fd_exp = 1'b1;
                    iw_exp = 1'b0;
                    nacc = 0;
                end
            endcase
        end
        cyc++;
    end

    // Monitor
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_d = '0;
    logic              prev_l = 1'b0;
    int                seen_n = 0;

    always @(negedge clk) begin
        wr_t w;
        px_t p;
        chk("s_ready", {31'd0, bus.s_ready}, {31'd0, ph == P_FILL});
        chk("image_written", {31'd0, bus.image_written}, {31'd0, iw_exp});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, fd_exp});
        if (bus.bram_we) begin
            if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(bus.bram_addr), 32'(w.a));
                chk("wr_data", 32'(bus.bram_din), 32'(w.d));
            end
        end
        if (prev_stall) begin
            chk("hold_valid", {31'd0, bus.m_valid}, 32'd1);
            chk("hold_data", 32'(bus.m_data), 32'(prev_d));
            chk("hold_last", {31'd0, bus.m_last}, {31'd0, prev_l});
        end
        if (bus.m_valid) begin
            if (seen_n != req_n) begin
                chk("first_latency", 32'(cyc - req_cyc), 32'd3);
                seen_n = req_n;
            end
            if (oq.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
                p = oq[0];
                chk("m_data", 32'(bus.m_data), 32'(p.d));
                chk("m_last", {31'd0, bus.m_last}, {31'd0, p.l});
                if (bus.m_ready && !rst) begin
                    void'(oq.pop_front());
                    npop++;
                    if (p.l) last_hs_cyc = cyc;
                end
            end
        end
        prev_stall = bus.m_valid && !bus.m_ready && !rst;
        prev_d     = bus.m_data;
        prev_l     = bus.m_last;
    end

    logic [15:0] lfsr = 16'd1;

    task automatic fill(input int vprob, input int req_beat, input int stop_beat,
                        input bit hold_valid, input bit rnd_data);
        int sent = 0;
        int budget = 0;
        bit hs;
        @(posedge clk); #1;
        bus.s_data       = rnd_data ? DATA_W'($urandom) : DATA_W'(sent);
        bus.s_valid      = ($urandom_range(99) < vprob);
        bus.read_request = (req_beat >= 0);
        while (sent < stop_beat && budget < 20000) begin
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            budget++;
            if (hs) begin
                sent++;
                bus.s_data = rnd_data ? DATA_W'($urandom) : DATA_W'(sent);
            end
            bus.s_valid      = ($urandom_range(99) < vprob);
            bus.read_request = (req_beat >= 0) && (sent >= req_beat) && (sent < stop_beat);
        end
        bus.s_valid      = hold_valid;
        bus.read_request = 1'b0;
        if (budget >= 20000) chk("fill_timeout", 32'(sent), 32'(stop_beat));
    endtask

    task automatic drain(input bit rnd_ready, input int stop_pops);
        int budget = 0;
        int pop0;
        bit done = 1'b0;
        while (ph != P_FULL && budget < 1000) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 1000) chk("full_timeout", 32'(ph), 32'(P_FULL));
        pop0 = npop;
        bus.read_request = 1'b1;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.read_request = 1'b0;
        budget = 0;
        while (!done && budget < 20000) begin
            if (rnd_ready) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                bus.m_ready = lfsr[0];
            end
            @(negedge clk);
            budget++;
            if (stop_pops >= 0 && npop - pop0 >= stop_pops) done = 1'b1;
            if (stop_pops < 0 && bus.frame_done) done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        bus.s_valid = 1'b0;
        if (!done) chk("drain_timeout", 32'(npop - pop0), 32'(N));
        else if (stop_pops < 0) begin
            chk("drain_beats", 32'(npop - pop0), 32'(N));
            chk("drain_queue_empty", 32'(oq.size()), 32'd0);
        end
    endtask

    task automatic do_reset(input bit wait_edge);
        if (wait_edge) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.read_request = 1'b0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_m_last", {31'd0, bus.m_last}, 32'd0);
        chk("rst_bram_we", {31'd0, bus.bram_we}, 32'd0);
        chk("rst_bram_addr", 32'(bus.bram_addr), 32'd0);
        chk("rst_bram_din", 32'(bus.bram_din), 32'd0);
        chk("rst_image_written", {31'd0, bus.image_written}, 32'd0);
        chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.read_request = 1'b0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        do_reset(1'b0);

        // Full-rate fill with data=i, then full-rate drain
        fill(100, -1, N, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("fill_writes_done", 32'(wq.size()), 32'd0);
        chk("fill_image_written", {31'd0, bus.image_written}, 32'd1);
        drain(1'b0, -1);

        // Same image, drain under pseudo-random backpressure
        fill(100, -1, N, 1'b0, 1'b0);
        drain(1'b1, -1);

        // read_request during fill is ignored; drain needs a fresh sample in FULL
        fill(70, 100, N, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("no_early_drain", {31'd0, bus.m_valid}, 32'd0);
        drain(1'b1, -1);

        // Reset mid-fill and mid-drain
        fill(100, -1, 400, 1'b1, 1'b0);
        do_reset(1'b1);
        fill(100, -1, N, 1'b0, 1'b1);
        drain(1'b0, 300);
        do_reset(1'b1);

        // Upstream keeps pushing while the image is held and drained
        fill(100, -1, N, 1'b1, 1'b1);
        drain(1'b1, -1);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
